wb_slave_regbank: RTL and testbench
===================================

// Module: wb_slave_regbank
// PURPOSE
// Parametrised WISHBONE classic-cycle slave register bank with a programmable wait-state count.
// It provides a W1C interrupt status register, an enable register and an ID register.
// Out-of-range and read-only-write accesses are terminated with an error cycle.
// It sits behind the processor-side WISHBONE bus and supplies a level interrupt int_o to the CPU.
// PARAMETERS
// ADDR_W      10            word-address width; wb_adr_i spans [ADDR_W+1:2], byte bits 1:0 are 00
// DATA_W      32            data width; must be a multiple of 8
// NUM_REGS    16            implemented registers, 4..2**ADDR_W
// WAIT_STATES 0             extra cycles inserted before the ack/err cycle, 0..15
// ID_VALUE    32'hB0B0_0001 read-only value of register 2
// PORTS
// wb_clk_i   in   1         single clock; everything is on its rising edge
// wb_rst_i   in   1         synchronous, active-low reset (0 = reset)
// wb_adr_i   in   ADDR_W    word address
// wb_dat_i   in   DATA_W    write data
// wb_dat_o   out  DATA_W    read data; valid while wb_ack_o=1
// wb_sel_i   in   DATA_W/8  byte select; sel[k] enables byte lane k
// wb_we_i    in   1         1 = write, 0 = read
// wb_cyc_i   in   1         bus cycle active
// wb_stb_i   in   1         strobe
// wb_ack_o   out  1         normal termination
// wb_err_o   out  1         error termination
// irq_evt_i  in   DATA_W    event pulses; bit i sets IRQ_STAT[i]
// int_o      out  1         registered interrupt: |(IRQ_STAT & IRQ_EN)
// BEHAVIOUR
// Reset (wb_rst_i=0 at an edge):
// - FSM goes to IDLE; all registers go to 0 (ID excepted).
// - wb_ack_o, wb_err_o and int_o are 0; wb_dat_o is 0.
// - An in-flight access is dropped with no ack/err and no write.
// Register map, by index wb_adr_i:
// - 0 IRQ_STAT: W1C; sel-gated byte lanes.
// - 1 IRQ_EN: RW.
// - 2 ID: RO; reads ID_VALUE; a write gives wb_err_o and no change.
// - 3..NUM_REGS-1 SCRATCH: RW.
// - Index >= NUM_REGS: wb_err_o for both read and write; read data is 0.
// FSM states IDLE, WAIT, RESP:
// - IDLE: cyc&stb at an edge latches adr, we, sel and dat_i.
//   - Goes to RESP if WAIT_STATES=0.
//   - Otherwise goes to WAIT with counter=WAIT_STATES-1.
// - WAIT: the counter decrements each cycle; at 0 -> RESP.
//   - cyc=0 or stb=0 aborts -> IDLE, with no write and no ack.
// - RESP: wb_ack_o = ~err & cyc & stb; wb_err_o = err & cyc & stb (combinational gate on a registered flag).
//   - A write commits at the edge ending RESP, only if ack was asserted.
//   - Next state is always IDLE.
// - Latency: ack/err appears WAIT_STATES+1 cycles after stb is sampled.
// - Minimum spacing is 2 cycles per access, because one IDLE cycle follows every RESP.
// - wb_dat_o is registered on entering RESP. It holds the register value plus any event bits set up to that edge.
// - wb_dat_o returns to 0 outside RESP.
// Byte lanes: writes update only lanes with sel[k]=1. sel=0 on a write is acked and changes nothing.
// IRQ_STAT per bit, each cycle:
// - next = (stat & ~w1c_clear) | irq_evt_i.
// - A set event wins over a simultaneous W1C clear.
// IRQ_EN has no effect on latching status bits.
// int_o = |(IRQ_STAT & IRQ_EN), registered; it lags a status or enable change by 1 cycle.
// At most one of wb_ack_o and wb_err_o is high in any cycle.
// TESTING
// Reset: hold wb_rst_i=0 for 3 cycles mid-WAIT with WAIT_STATES=3 -> no ack; outputs 0; reg 3 unchanged.
// Write then read, WAIT_STATES=0: write reg 3=32'hDEAD_BEEF, sel=4'hF, then write 32'h1234_5678 with sel=4'b0101.
//   -> Read of reg 3 returns 32'hDE34_BE78; ack comes 1 cycle after stb.
// WAIT_STATES=2: read ID -> ack exactly 3 cycles after stb, dat_o=32'hB0B0_0001.
//   Write ID -> err_o for 1 cycle, no ack.
// Error paths: address NUM_REGS and address 2**ADDR_W-1, read and write -> err_o=1, ack_o=0, dat_o=0.
// IRQ: IRQ_EN=32'h1; pulse irq_evt_i[0] -> int_o=1 one cycle after IRQ_STAT[0] sets.
//   W1C of 32'h1 in the same cycle as a new irq_evt_i[0] -> bit stays 1.
//   A lone W1C -> int_o falls 1 cycle later.
// Abort: WAIT_STATES=3, stb dropped in WAIT -> no ack/err, no write; the next access completes normally.

Source files
------------

// File: rtl/wb_slave_regbank.sv
// WISHBONE classic-cycle register bank: W1C IRQ status, IRQ enable, RO ID and scratch registers,
// with a fixed number of wait states before each ack/err termination.
module wb_slave_regbank #(
    parameter int                ADDR_W      = 10,
    parameter int                DATA_W      = 32,
    parameter int                NUM_REGS    = 16,
    parameter int                WAIT_STATES = 0,
    parameter logic [DATA_W-1:0] ID_VALUE    = 32'hB0B0_0001
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [ADDR_W-1:0]   wb_adr_i,
    input  logic [DATA_W-1:0]   wb_dat_i,
    output logic [DATA_W-1:0]   wb_dat_o,
    input  logic [DATA_W/8-1:0] wb_sel_i,
    input  logic                wb_we_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    input  logic [DATA_W-1:0]   irq_evt_i,
    output logic                int_o
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e                          state_q, state_d;
    logic [3:0]                      cnt_q, cnt_d;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [IDX_W-1:0]                idx_q;
    logic                            we_q, err_q;
    logic [NB-1:0]                   sel_q;
    logic [DATA_W-1:0]               dat_q, dat_o_q, dat_o_d, mask;
    logic                            int_q;

    logic             req, req_err, cur_err, wr_en;
    logic [IDX_W-1:0] req_idx, cur_idx;

    assign req     = wb_cyc_i & wb_stb_i;
    assign req_idx = wb_adr_i[IDX_W-1:0];
    assign req_err = ({1'b0, wb_adr_i} >= (ADDR_W+1)'(NUM_REGS))
                   | (wb_we_i & (wb_adr_i == ADDR_W'(2)));
    // With zero wait states RESP is entered on the latching edge, so read the live request.
    assign cur_idx = (state_q == S_IDLE) ? req_idx : idx_q;
    assign cur_err = (state_q == S_IDLE) ? req_err : err_q;
    assign wr_en   = wb_ack_o & we_q;

    for (genvar k = 0; k < NB; k++) begin : g_mask
        assign mask[8*k +: 8] = {8{sel_q[k]}};
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (!req)                state_d = S_IDLE;
                else if (cnt_q == 4'd0)  state_d = S_RESP;
                else                     cnt_d   = cnt_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wb_ack_o = 1'b0;
        wb_err_o = 1'b0;
        if (state_q == S_RESP) begin
            wb_ack_o = ~err_q & req;
            wb_err_o = err_q & req;
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_en && idx_q != IDX_W'(0))
            regs_d[idx_q] = (regs_q[idx_q] & ~mask) | (dat_q & mask);
        // Event set takes priority over a same-cycle W1C clear.
        regs_d[0] = (regs_q[0] & ~((wr_en && idx_q == IDX_W'(0)) ? (dat_q & mask) : '0)) | irq_evt_i;
        dat_o_d = '0;
        if (state_d == S_RESP && !cur_err)
            dat_o_d = (cur_idx == IDX_W'(2)) ? ID_VALUE : regs_d[cur_idx];
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            regs_q  <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            dat_o_q <= '0;
            int_q   <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            dat_o_q <= dat_o_d;
            int_q   <= |(regs_q[0] & regs_q[1]);
            if (state_q == S_IDLE && req) begin
                idx_q <= req_idx;
                we_q  <= wb_we_i;
                err_q <= req_err;
                sel_q <= wb_sel_i;
                dat_q <= wb_dat_i;
            end
        end
    end

    assign wb_dat_o = dat_o_q;
    assign int_o    = int_q;

endmodule

// File: tb/tb_wb_slave_regbank.sv
// Scoreboarded bench for wb_slave_regbank: three instances (0, 2 and 3 wait states) share one
// master; expected responses are queued at issue and checked by an independent monitor.
module tb_wb_slave_regbank;
    localparam int          NR  = 16;
    localparam logic [31:0] IDV = 32'hB0B0_0001;

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [9:0]  adr = '0;
    logic [31:0] dat = '0, evt = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
    int          dsel = 0;

    logic [2:0]       ack_v, err_v, int_v;
    logic [2:0][31:0] dato_v;

    int   cyc_cnt = 0, n_cmp = 0, n_bad = 0;
    exp_t exp_q[$];
    logic [31:0] model [3][NR];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wb_slave_regbank #(.WAIT_STATES(g == 0 ? 0 : (g == 1 ? 2 : 3))) u_dut (
            .wb_clk_i  (clk),
            .wb_rst_i  (rst_n),
            .wb_adr_i  (adr),
            .wb_dat_i  (dat),
            .wb_dat_o  (dato_v[g]),
            .wb_sel_i  (sel),
            .wb_we_i   (we),
            .wb_cyc_i  (cyc && (dsel == g)),
            .wb_stb_i  (stb && (dsel == g)),
            .wb_ack_o  (ack_v[g]),
            .wb_err_o  (err_v[g]),
            .irq_evt_i ((dsel == g) ? evt : 32'h0),
            .int_o     (int_v[g])
        );
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    function automatic logic [31:0] bmask(input logic [3:0] s);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{s[k]}};
        return m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++)
            for (int r = 0; r < NR; r++) model[d][r] = '0;
    endtask

    // Issue one access from a negedge; returns at the negedge after the terminating cycle.
    task automatic access(input int d, input logic [9:0] a, input logic w, input logic [31:0] wd,
                          input logic [3:0] s, input logic [31:0] ev);
        exp_t e;
        int   ai;
        logic is_err, seen;
        ai     = int'(a);
        is_err = (ai >= NR) || (w && ai == 2);
        e.err  = is_err;
        e.chk  = !w || is_err;
        e.data = is_err ? 32'h0 : ((ai == 2) ? IDV : model[d][ai]);
        e.due  = cyc_cnt + ws_of(d) + 1;
        exp_q.push_back(e);
        dsel = d; adr = a; we = w; dat = wd; sel = s; cyc = 1'b1; stb = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (ack_v[d] || err_v[d]) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL resp_timeout: dut %0d adr %0d got no ack/err, expected one", d, ai);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            cyc = 1'b0; stb = 1'b0;
        end else begin
            evt = ev;
            @(posedge clk);
            #1;
            cyc = 1'b0; stb = 1'b0; evt = '0;
            if (w && !is_err) begin
                if (ai == 0) model[d][0] = (model[d][0] & ~(wd & bmask(s))) | ev;
                else begin
                    model[d][ai] = (model[d][ai] & ~bmask(s)) | (wd & bmask(s));
                    model[d][0] |= ev;
                end
            end else begin
                model[d][0] |= ev;
            end
        end
        @(negedge clk);
        chk("idle_after_resp", 32'({ack_v[d], err_v[d]}), 32'h0);
        chk("dat_idle", dato_v[d], 32'h0);
    endtask

    task automatic pulse_evt(input int d, input logic [31:0] bits);
        dsel = d; evt = bits;
        @(posedge clk);
        #1 evt = '0;
        model[d][0] |= bits;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (ack_v[dsel] || err_v[dsel]) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_resp: dut %0d ack=%b err=%b, expected no response",
                         dsel, ack_v[dsel], err_v[dsel]);
            end else begin
                e = exp_q.pop_front();
                if (ack_v[dsel] !== ~e.err || err_v[dsel] !== e.err ||
                    (e.chk && dato_v[dsel] !== e.data) || cyc_cnt != e.due) begin
                    n_bad++;
                    $display("FAIL resp: dut %0d got ack=%b err=%b dat=%h cyc=%0d, expected ack=%b err=%b dat=%h cyc=%0d",
                             dsel, ack_v[dsel], err_v[dsel], dato_v[dsel], cyc_cnt,
                             ~e.err, e.err, e.data, e.due);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  ra;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", 32'({ack_v, err_v, int_v}), 32'h0);
        for (int d = 0; d < 3; d++) chk("reset_dat", dato_v[d], 32'h0);
        rst_n = 1'b1;

        // Reset during WAIT drops the in-flight write.
        access(2, 10'd3, 1'b1, 32'hA5A5_A5A5, 4'hF, 32'h0);
        dsel = 2; adr = 10'd3; we = 1'b1; dat = 32'h1111_1111; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            chk("rst_mid_ctrl", 32'({ack_v, err_v, int_v}), 32'h0);
            chk("rst_mid_dat", dato_v[2], 32'h0);
        end
        cyc = 1'b0; stb = 1'b0; rst_n = 1'b1;
        model_reset();
        access(2, 10'd3, 1'b0, 32'h0, 4'hF, 32'h0);

        // Byte-lane merge, zero wait states.
        access(0, 10'd3, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0);
        access(0, 10'd3, 1'b1, 32'h1234_5678, 4'b0101, 32'h0);
        access(0, 10'd3, 1'b0, 32'h0, 4'hF, 32'h0);
        chk("merge_model", model[0][3], 32'hDE34_BE78);
        access(0, 10'd5, 1'b1, 32'hFFFF_FFFF, 4'h0, 32'h0);
        access(0, 10'd5, 1'b0, 32'h0, 4'hF, 32'h0);

        // ID register with two wait states.
        access(1, 10'd2, 1'b0, 32'h0, 4'hF, 32'h0);
        access(1, 10'd2, 1'b1, 32'h5555_5555, 4'hF, 32'h0);
        access(1, 10'd2, 1'b0, 32'h0, 4'hF, 32'h0);

        // Out-of-range addresses.
        for (int d = 0; d < 3; d += 2) begin
            access(d, 10'd16,   1'b0, 32'h0, 4'hF, 32'h0);
            access(d, 10'd16,   1'b1, 32'h1357_9BDF, 4'hF, 32'h0);
            access(d, 10'd1023, 1'b0, 32'h0, 4'hF, 32'h0);
            access(d, 10'd1023, 1'b1, 32'h2468_ACE0, 4'hF, 32'h0);
        end

        // Interrupt path on the zero-wait instance.
        access(0, 10'd1, 1'b1, 32'h1, 4'hF, 32'h0);
        pulse_evt(0, 32'h1);
        @(negedge clk); chk("int_lag", 32'(int_v[0]), 32'h0);
        @(negedge clk); chk("int_set", 32'(int_v[0]), 32'h1);
        access(0, 10'd0, 1'b0, 32'h0, 4'hF, 32'h0);
        access(0, 10'd0, 1'b1, 32'h1, 4'hF, 32'h1);
        chk("w1c_vs_evt_model", model[0][0], 32'h1);
        @(negedge clk); chk("int_keep", 32'(int_v[0]), 32'h1);
        access(0, 10'd0, 1'b0, 32'h0, 4'hF, 32'h0);
        access(0, 10'd0, 1'b1, 32'h1, 4'hF, 32'h0);
        chk("int_hold", 32'(int_v[0]), 32'h1);
        @(negedge clk); chk("int_clear", 32'(int_v[0]), 32'h0);
        access(0, 10'd0, 1'b0, 32'h0, 4'hF, 32'h0);

        // Abort in WAIT with three wait states.
        dsel = 2; adr = 10'd4; we = 1'b1; dat = 32'hCAFE_F00D; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); @(posedge clk);
        #1 cyc = 1'b0; stb = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_quiet", 32'({ack_v[2], err_v[2]}), 32'h0);
        end
        access(2, 10'd4, 1'b0, 32'h0, 4'hF, 32'h0);
        access(2, 10'd4, 1'b1, 32'h5555_AAAA, 4'hF, 32'h0);
        access(2, 10'd4, 1'b0, 32'h0, 4'hF, 32'h0);

        // Random traffic across all three instances.
        for (int i = 0; i < 60; i++) begin
            ra = ($urandom_range(0, 9) == 0) ? 10'd1023 : 10'($urandom_range(0, 19));
            access($urandom_range(0, 2), ra, 1'($urandom_range(0, 1)), $urandom,
                   4'($urandom_range(0, 15)), 32'h0);
        end

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
